// File: rtl/salsa_r.sv
// Salsa20 add-rotate primitive: out = ROTL(a + b, sh), registered.
// Define SALSA_R_PIPE2_EN to split add and rotate into two registered stages.
module salsa_r #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sh,
  output logic             out_valid,
  output logic [WIDTH-1:0] out
);

  // Circular left rotate; a right shift of WIDTH yields zero, so sh=0 passes x through.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                             input logic [SHW-1:0]   s);
    return (x << s) | (x >> (WIDTH - int'(s)));
  endfunction

  logic [WIDTH-1:0] sum;
  assign sum = a + b;

`ifdef SALSA_R_PIPE2_EN
  logic             vld_p0;
  logic [WIDTH-1:0] sum_p0;
  logic [SHW-1:0]   sh_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      sum_p0 <= '0;
      sh_p0  <= '0;
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else begin
      // p0: modular sum and rotate amount
      vld_p0 <= in_valid;
      if (in_valid) begin
        sum_p0 <= sum;
        sh_p0  <= sh;
      end
      // p1: rotated result, held while no new op arrives
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        res_p1 <= rotl(sum_p0, sh_p0);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out       = res_p1;
`else
  logic             vld_p0;
  logic [WIDTH-1:0] res_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      res_p0 <= '0;
    end else begin
      // p0: add and rotate in one stage, held while no new op arrives
      vld_p0 <= in_valid;
      if (in_valid) begin
        res_p0 <= rotl(sum, sh);
      end
    end
  end

  assign out_valid = vld_p0;
  assign out       = res_p0;
`endif

endmodule

// File: tb/tb_salsa_r.sv
// Self-checking bench for salsa_r: directed vector table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_salsa_r;

`ifdef SALSA_R_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sh;
  logic        out_valid;
  logic [31:0] out;

  salsa_r #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sh(sh),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] val;
  } pend_t;

  pend_t       pq[$];
  int          edge_n  = 0;
  logic [31:0] exp_out = 32'h0;
  logic        exp_vld = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Rotation by moving each bit to its new position.
  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i + s) % 32] = x[i];
    return r;
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                         input logic [4:0] s);
    logic [31:0] sm;
    sm = x + y;
    return ref_rotl(sm, int'(s));
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic step(input logic r, input logic v, input logic [31:0] ia,
                      input logic [31:0] ib, input logic [4:0] ish);
    rst = r; in_valid = v; a = ia; b = ib; sh = ish;
    @(posedge clk);
    edge_n++;
    if (r) begin
      pq.delete();
      exp_out = 32'h0;
      exp_vld = 1'b0;
    end else begin
      exp_vld = 1'b0;
      if (v) pq.push_back('{due: edge_n + LAT - 1, val: ref_op(ia, ib, ish)});
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        exp_out = pq[0].val;
        exp_vld = 1'b1;
        void'(pq.pop_front());
      end
    end
    #1;
    chk1("model_vld", out_valid, exp_vld);
    chk32("model_out", out, exp_out);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, $urandom, $urandom, 5'($urandom));
  endtask

  logic [31:0] held;

  initial begin
    vecs[0] = '{a: 32'h00000001, b: 32'h00000000, sh: 5'd7,  exp: 32'h00000080};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, sh: 5'd9,  exp: 32'h00000000};
    vecs[2] = '{a: 32'h80000000, b: 32'h00000000, sh: 5'd1,  exp: 32'h00000001};
    vecs[3] = '{a: 32'h00000001, b: 32'h00000000, sh: 5'd18, exp: 32'h00040000};
    vecs[4] = '{a: 32'h12345678, b: 32'h11111111, sh: 5'd0,  exp: 32'h23456789};
    vecs[5] = '{a: 32'hF0000000, b: 32'h20000001, sh: 5'd31, exp: 32'h88000000};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sh = '0;
    step(1'b1, 1'b1, 32'hDEADBEEF, 32'h1, 5'd3);
    step(1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
    chk1("reset_vld", out_valid, 1'b0);
    chk32("reset_out", out, 32'h0);

    // Directed table: one op, then wait out the latency.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sh);
      for (int k = 1; k < LAT; k++) idle();
      chk1("vec_vld", out_valid, 1'b1);
      chk32("vec_out", out, vecs[i].exp);
      idle();
      chk1("vec_vld_drop", out_valid, 1'b0);
      chk32("vec_out_hold", out, vecs[i].exp);
    end

    // Back-to-back Salsa amounts, then hold.
    step(1'b0, 1'b1, 32'h00000003, 32'h00000000, 5'd7);
    step(1'b0, 1'b1, 32'h00000003, 32'h00000000, 5'd9);
    step(1'b0, 1'b1, 32'h00000003, 32'h00000000, 5'd13);
    for (int k = 1; k < LAT; k++) idle();
    chk32("b2b_last", out, 32'h00006000);
    chk1("b2b_last_vld", out_valid, 1'b1);
    idle();
    idle();
    chk1("b2b_idle_vld", out_valid, 1'b0);
    chk32("b2b_hold", out, 32'h00006000);

    // Reset while operations are in flight and one is presented.
    step(1'b0, 1'b1, 32'h11111111, 32'h22222222, 5'd4);
    step(1'b0, 1'b1, 32'h01010101, 32'h10101010, 5'd8);
    step(1'b1, 1'b1, 32'h0000FFFF, 32'h00000001, 5'd2);
    chk1("midrst_vld", out_valid, 1'b0);
    chk32("midrst_out", out, 32'h0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk1("midrst_no_stale", out_valid, 1'b0);
    end
    // First cycle after reset accepts an op.
    step(1'b0, 1'b1, 32'h00000001, 32'h00000001, 5'd18);
    for (int k = 1; k < LAT; k++) idle();
    chk32("post_rst_out", out, 32'h00080000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           $urandom, $urandom, 5'($urandom));
    end
    for (int k = 0; k < LAT + 1; k++) idle();

    held = out;
    idle();
    chk32("final_hold", out, held);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
